// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field, HALT opcode and reset PC.
// Used by the fetch stage and its pc_counter.
package cpu_pkg;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;

  localparam logic [3:0] OP_HALT = 4'hF;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam pc_t DEF_RESET_PC = 8'h00;

  function automatic logic is_halt(input instr_t instr);
    return instr[OP_HI:OP_LO] == OP_HALT;
  endfunction
endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage and its surroundings: instruction memory port,
// redirect input and the IF/ID output handshake.
interface fetch_if
  import cpu_pkg::*;
();
  pc_t    imem_addr;
  instr_t imem_data;
  logic   redirect_valid;
  pc_t    redirect_pc;
  // out_valid/out_ready: a transfer happens on each rising edge where both are 1.
  // While out_valid=1 and out_ready=0 the producer holds out_instr/out_pc stable;
  // out_valid may only drop after a transfer or on a redirect flush.
  logic   out_valid;
  logic   out_ready;
  instr_t out_instr;
  pc_t    out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register: synchronous reset, redirect load, increment enable.
// Increment wraps modulo 2^PC_W.
module pc_counter
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC = DEF_RESET_PC
) (
  input  logic clk,
  input  logic rst,
  input  logic load_en_i,
  input  pc_t  load_pc_i,
  input  logic inc_en_i,
  output pc_t  pc_o
);
  pc_t pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = load_pc_i;
    end else if (inc_en_i) begin
      pc_d = pc_q + pc_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register with valid/ready output, redirect
// flush and saturating handoff counter. HALT stop is built when FETCH_HALT_EN is defined.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC = DEF_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  fetch_if.master          bus,
  output logic [CNT_W-1:0] fetch_count,
  output logic             halted
);
  pc_t              pc;
  logic             load, handoff, inc_en;
  logic             out_valid_q, out_valid_d;
  instr_t           out_instr_q, out_instr_d;
  pc_t              out_pc_q, out_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q;
`ifdef FETCH_HALT_EN
  logic             halted_d;
`endif

  assign load    = !out_valid_q || bus.out_ready;
  assign handoff = out_valid_q && bus.out_ready;

  pc_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load_en_i (bus.redirect_valid),
    .load_pc_i (bus.redirect_pc),
    .inc_en_i  (inc_en),
    .pc_o      (pc)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    inc_en      = 1'b0;
`ifdef FETCH_HALT_EN
    halted_d    = halted_q;
`endif
    if (bus.redirect_valid) begin
      out_valid_d = 1'b0;
`ifdef FETCH_HALT_EN
      halted_d    = 1'b0;
`endif
    end else if (load && !halted_q) begin
      out_instr_d = bus.imem_data;
      out_pc_d    = pc;
      out_valid_d = 1'b1;
      inc_en      = 1'b1;
`ifdef FETCH_HALT_EN
      halted_d    = is_halt(bus.imem_data);
`endif
    end else if (halted_q && bus.out_ready) begin
      // Once halted, the HALT itself drains on handoff and nothing replaces it.
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (handoff && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      count_q     <= count_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  assign bus.imem_addr = pc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign fetch_count   = count_q;
  assign halted        = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table, handoff scoreboard, reset and HALT sequences.
module tb_fetch_unit;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if          bus ();
  logic [CNT_W-1:0] fetch_count;
  logic             halted;
  instr_t           mem [256];

  assign bus.imem_data = mem[bus.imem_addr];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fetch_count (fetch_count),
    .halted      (halted)
  );

  int total = 0;
  int bad   = 0;
  logic [PC_W+INSTR_W-1:0] exp_q[$];

  function automatic instr_t mem_init(input int a);
    pc_t aa;
    aa = pc_t'(a);
    case (aa)
      8'h00:   return 16'h0000;
      8'h01:   return 16'h1123;
      8'h02:   return 16'h2456;
      8'h03:   return 16'h3789;
      default: return {4'h7, aa[3:0], aa};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input pc_t p, input instr_t ins);
    exp_q.push_back({p, ins});
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_handoff", {8'h0, bus.out_pc, bus.out_instr}, 32'hFFFF_FFFF);
      end else begin
        check("sb_handoff", {8'h0, bus.out_pc, bus.out_instr}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic             ready;
    logic             rv;
    pc_t              rpc;
    logic             chk_data;
    logic             e_valid;
    pc_t              e_pc;
    instr_t           e_instr;
    pc_t              e_addr;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic rv, input pc_t rpc, input logic chk,
                              input logic v, input pc_t p, input pc_t a, input int c);
    vec_t t;
    t.ready = r; t.rv = rv; t.rpc = rpc; t.chk_data = chk;
    t.e_valid = v; t.e_pc = p; t.e_instr = mem_init(int'(p)); t.e_addr = a;
    t.e_cnt = CNT_W'(c);
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mem_init(i);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    //            rdy rv rpc   chk v  pc     addr   cnt
    vecs[0]  = mk(1, 0, 8'h00, 1, 1, 8'h00, 8'h01, 0);
    vecs[1]  = mk(1, 0, 8'h00, 1, 1, 8'h01, 8'h02, 1);
    vecs[2]  = mk(1, 0, 8'h00, 1, 1, 8'h02, 8'h03, 2);
    vecs[3]  = mk(1, 0, 8'h00, 1, 1, 8'h03, 8'h04, 3);
    vecs[4]  = mk(1, 0, 8'h00, 1, 1, 8'h04, 8'h05, 4);
    vecs[5]  = mk(0, 0, 8'h00, 1, 1, 8'h04, 8'h05, 4);
    vecs[6]  = mk(0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 4);
    vecs[7]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 8'h01, 4);
    vecs[8]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 8'h01, 4);
    vecs[9]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 8'h01, 4);
    vecs[10] = mk(0, 0, 8'h00, 1, 1, 8'h00, 8'h01, 4);
    vecs[11] = mk(1, 0, 8'h00, 1, 1, 8'h01, 8'h02, 5);
    vecs[12] = mk(0, 0, 8'h00, 1, 1, 8'h01, 8'h02, 5);
    vecs[13] = mk(0, 1, 8'h40, 0, 0, 8'h00, 8'h40, 5);
    vecs[14] = mk(0, 0, 8'h00, 1, 1, 8'h40, 8'h41, 5);
    vecs[15] = mk(1, 1, 8'hFE, 0, 0, 8'h00, 8'hFE, 6);
    vecs[16] = mk(1, 0, 8'h00, 1, 1, 8'hFE, 8'hFF, 6);
    vecs[17] = mk(1, 0, 8'h00, 1, 1, 8'hFF, 8'h00, 7);
    vecs[18] = mk(1, 0, 8'h00, 1, 1, 8'h00, 8'h01, 8);
    vecs[19] = mk(1, 0, 8'h00, 1, 1, 8'h01, 8'h02, 9);
    vecs[20] = mk(1, 1, 8'h10, 0, 0, 8'h00, 8'h10, 10);
    vecs[21] = mk(1, 0, 8'h00, 1, 1, 8'h10, 8'h11, 10);

    // handoffs the table produces, in order
    push_exp(8'h00, mem_init(8'h00)); push_exp(8'h01, mem_init(8'h01));
    push_exp(8'h02, mem_init(8'h02)); push_exp(8'h03, mem_init(8'h03));
    push_exp(8'h00, mem_init(8'h00)); push_exp(8'h40, mem_init(8'h40));
    push_exp(8'hFE, mem_init(8'hFE)); push_exp(8'hFF, mem_init(8'hFF));
    push_exp(8'h00, mem_init(8'h00)); push_exp(8'h01, mem_init(8'h01));

    // reset state
    step(); step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_instr", 32'(bus.out_instr), 32'd0);
    check("rst_pc",    32'(bus.out_pc),    32'd0);
    check("rst_addr",  32'(bus.imem_addr), 32'(DEF_RESET_PC));
    check("rst_count", 32'(fetch_count),   32'd0);
    check("rst_halted", 32'(halted),       32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.out_ready      = vecs[i].ready;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      step();
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_addr", i),  32'(bus.imem_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_count", i), 32'(fetch_count),   32'(vecs[i].e_cnt));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_pc", i),    32'(bus.out_pc),    32'(vecs[i].e_pc));
        check($sformatf("v%0d_instr", i), 32'(bus.out_instr), 32'(vecs[i].e_instr));
      end
    end

    // reset mid-stream overrides redirect and a pending handoff
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h33;
    step();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_instr", 32'(bus.out_instr), 32'd0);
    check("mid_rst_pc",    32'(bus.out_pc),    32'd0);
    check("mid_rst_addr",  32'(bus.imem_addr), 32'(DEF_RESET_PC));
    check("mid_rst_count", 32'(fetch_count),   32'd0);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_pc",    32'(bus.out_pc),    32'(DEF_RESET_PC));
    check("post_rst_instr", 32'(bus.out_instr), 32'(mem_init(int'(DEF_RESET_PC))));
    check("post_rst_count", 32'(fetch_count),   32'd0);

    // opcode 4'hF at address 2
    mem[2] = 16'hF000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    push_exp(8'h00, 16'h0000); push_exp(8'h01, 16'h1123); push_exp(8'h02, 16'hF000);
    step(); step(); step();
    check("halt_load_pc",   32'(bus.out_pc),    32'h02);
    check("halt_load_addr", 32'(bus.imem_addr), 32'h03);
`ifdef FETCH_HALT_EN
    check("halt_set", 32'(halted), 32'd1);
    step();
    check("halt_drained_valid", 32'(bus.out_valid), 32'd0);
    check("halt_drained_count", 32'(fetch_count),   32'd3);
    check("halt_drained_addr",  32'(bus.imem_addr), 32'h03);
    step();
    check("halt_frozen_valid", 32'(bus.out_valid), 32'd0);
    check("halt_frozen_addr",  32'(bus.imem_addr), 32'h03);
    check("halt_frozen_flag",  32'(halted),        32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h00;
    step();
    bus.redirect_valid = 1'b0;
    check("halt_clear_flag", 32'(halted),        32'd0);
    check("halt_clear_addr", 32'(bus.imem_addr), 32'h00);
    step();
    bus.out_ready = 1'b0;
    check("halt_restart_valid", 32'(bus.out_valid), 32'd1);
    check("halt_restart_pc",    32'(bus.out_pc),    32'h00);
    check("halt_restart_count", 32'(fetch_count),   32'd3);
`else
    check("nohalt_flag0", 32'(halted), 32'd0);
    step();
    bus.out_ready = 1'b0;
    check("nohalt_valid", 32'(bus.out_valid), 32'd1);
    check("nohalt_pc",    32'(bus.out_pc),    32'h03);
    check("nohalt_instr", 32'(bus.out_instr), 32'h3789);
    check("nohalt_count", 32'(fetch_count),   32'd3);
    check("nohalt_flag1", 32'(halted),        32'd0);
`endif

    // ---------------- final report ----------------
    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
